// File: rtl/ula_pkg.sv
// Shared ULA constants and state encoding for the sequential matrix multiplier.
// Latency: none (definitions only).
// Backpressure: none.
package ula_pkg;
    localparam int N = 5;
    localparam int W = 8;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/mat_mac.sv
// Signed WxW multiply into an ACC_W accumulator, with a combinational saturate-to-W view of the running sum.
// Latency: accumulator updates one edge after en; sat_out is combinational on acc + a*b.
// Backpressure: none; en gates the update.
module mat_mac #(
    parameter int W     = 8,
    parameter int ACC_W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sat_out
);
    localparam logic signed [ACC_W-1:0] HI = ACC_W'((1 << (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] LO = ~HI;

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        prod  = $signed(a) * $signed(b);
        sum   = acc_q + ACC_W'(prod);
        acc_d = acc_q;
        if (en) begin
            acc_d = clear ? '0 : sum;
        end
        sat_out = sum[W-1:0];
        if (sum > HI) begin
            sat_out = HI[W-1:0];
        end else if (sum < LO) begin
            sat_out = LO[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequential NxN signed int8 matrix multiply using one shared MAC, row/col/term order.
// Latency: N^3 RUN cycles plus one DONE cycle after start; Pp updates entering DONE.
// Backpressure: none; start is ignored while busy and never queued.
module matmul_seq_ctrl #(
    parameter int N     = ula_pkg::N,
    parameter int W     = ula_pkg::W,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [N*N*W-1:0] Aa,
    input  logic [N*N*W-1:0] Bb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [N*N*W-1:0] Pp
);
    ula_pkg::state_t state_q, state_d;
    logic [2:0]       i_q, i_d;
    logic [2:0]       j_q, j_d;
    logic [2:0]       k_q, k_d;
    logic [2:0]       op_q, op_d;
    logic [N*N*W-1:0] a_q, a_d;
    logic [N*N*W-1:0] b_q, b_d;
    logic [N*N*W-1:0] buf_q, buf_d;
    logic [N*N*W-1:0] pp_q, pp_d;

    logic         mac_en;
    logic         mac_clr;
    logic [W-1:0] mac_a;
    logic [W-1:0] mac_b;
    logic [W-1:0] mac_sat;

    mat_mac #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .en      (mac_en),
        .clear   (mac_clr),
        .a       (mac_a),
        .b       (mac_b),
        .sat_out (mac_sat)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        buf_d   = buf_q;
        pp_d    = pp_q;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        mac_a   = a_q[(int'(i_q) * N + int'(k_q)) * W +: W];
        mac_b   = b_q[(int'(k_q) * N + int'(j_q)) * W +: W];

        case (state_q)
            ula_pkg::IDLE: begin
                if (start) begin
                    op_d = op;
                    if (op == ula_pkg::OP_MUL) begin
                        a_d     = Aa;
                        b_d     = Bb;
                        state_d = ula_pkg::RUN;
                    end else begin
                        pp_d    = '0;
                        state_d = ula_pkg::DONE;
                    end
                end
            end
            ula_pkg::RUN: begin
                mac_en = 1'b1;
                if (k_q == 3'(N - 1)) begin
                    // Last term: the saturated sum lands in the buffer and the MAC restarts at zero.
                    mac_clr = 1'b1;
                    buf_d[(int'(i_q) * N + int'(j_q)) * W +: W] = mac_sat;
                    k_d = '0;
                    if (j_q == 3'(N - 1)) begin
                        j_d = '0;
                        if (i_q == 3'(N - 1)) begin
                            i_d     = '0;
                            pp_d    = buf_d;
                            state_d = ula_pkg::DONE;
                        end else begin
                            i_d = i_q + 3'd1;
                        end
                    end else begin
                        j_d = j_q + 3'd1;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ula_pkg::DONE: begin
                state_d = ula_pkg::IDLE;
            end
            default: begin
                state_d = ula_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ula_pkg::IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            buf_q   <= '0;
            pp_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            buf_q   <= buf_d;
            pp_q    <= pp_d;
        end
    end

    assign busy = (state_q != ula_pkg::IDLE);
    assign done = (state_q == ula_pkg::DONE);
    assign err  = done && (op_q != ula_pkg::OP_MUL);
    assign Pp   = pp_q;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: hand-computed results, cycle counts and handshake pulses.
module tb_matmul_seq_ctrl;
    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [199:0] Aa;
    logic [199:0] Bb;
    logic         busy;
    logic         done;
    logic         err;
    logic [199:0] Pp;

    int n_checks = 0;
    int n_errors = 0;

    matmul_seq_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .Aa    (Aa),
        .Bb    (Bb),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .Pp    (Pp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [199:0] fill(input logic [7:0] v);
        logic [199:0] r;
        for (int e = 0; e < 25; e++) r[e*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [199:0] ident();
        logic [199:0] r;
        r = '0;
        for (int e = 0; e < 5; e++) r[(6*e)*8 +: 8] = 8'd1;
        return r;
    endfunction

    // mode 0: plain run; 1: operand change at cycle 10, extra start at cycle 40; 2: reset at cycle 60
    task automatic run_op(input string tag, input logic [2:0] opc, input logic [199:0] a,
                          input logic [199:0] b, input int mode, input int exp_busy,
                          input logic exp_err, input logic [199:0] exp_pp);
        int           cyc;
        int           busy_cnt;
        int           done_cnt;
        int           done_cyc;
        logic         err_seen;
        logic [199:0] pp_prev;
        pp_prev = Pp;
        start   = 1'b1;
        op      = opc;
        Aa      = a;
        Bb      = b;
        step();
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        err_seen = 1'b0;
        while (busy && cyc < 300) begin
            busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                err_seen = err;
            end
            if (exp_busy > 1 && cyc == exp_busy - 1) check({tag, "_pp_hold"}, Pp, pp_prev);
            if (mode == 1 && cyc == 10) begin
                Aa = ~a;
                Bb = ~b;
                op = 3'b001;
            end
            start = (mode == 1 && cyc == 40);
            if (mode == 2 && cyc == 60) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check({tag, "_rst_busy"}, 200'(busy), 200'(0));
                check({tag, "_rst_done"}, 200'(done), 200'(0));
                check({tag, "_rst_pp"}, Pp, '0);
                return;
            end
            step();
            cyc++;
        end
        check({tag, "_busy_cycles"}, 200'(busy_cnt), 200'(exp_busy));
        check({tag, "_done_count"}, 200'(done_cnt), 200'(1));
        check({tag, "_done_cycle"}, 200'(done_cyc), 200'(exp_busy));
        check({tag, "_err"}, 200'(err_seen), 200'(exp_err));
        check({tag, "_pp"}, Pp, exp_pp);
    endtask

    initial begin
        logic [199:0] seq_b;
        logic [199:0] shift_exp;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        Aa    = '0;
        Bb    = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_busy", 200'(busy), 200'(0));
        check("reset_done", 200'(done), 200'(0));
        check("reset_err", 200'(err), 200'(0));
        check("reset_pp", Pp, '0);

        // Reset and start on the same edge: reset must win
        rst   = 1'b1;
        start = 1'b1;
        op    = 3'b010;
        Aa    = ident();
        Bb    = fill(8'd3);
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 200'(busy), 200'(0));
        step();
        check("rst_start_busy_later", 200'(busy), 200'(0));

        run_op("ident_x3", 3'b010, ident(), fill(8'd3), 0, 126, 1'b0, fill(8'd3));
        run_op("sat_pos", 3'b010, fill(8'd127), fill(8'd127), 0, 126, 1'b0, fill(8'h7F));
        run_op("sat_neg", 3'b010, fill(8'h80), fill(8'd127), 0, 126, 1'b0, fill(8'h80));
        run_op("two_x_m3", 3'b010, fill(8'd2), fill(8'hFD), 0, 126, 1'b0, fill(8'hE2));
        run_op("a00_five", 3'b010, 200'h05, ident(), 0, 126, 1'b0, 200'h05);
        run_op("bad_op", 3'b001, fill(8'd9), fill(8'd9), 0, 1, 1'b1, '0);
        step();
        check("bad_op_idle", 200'(busy), 200'(0));

        // A has a single 1 at [0][1], so row 0 of P is row 1 of B
        seq_b     = '0;
        shift_exp = '0;
        for (int e = 0; e < 25; e++) seq_b[e*8 +: 8] = 8'(e);
        for (int c = 0; c < 5; c++) shift_exp[c*8 +: 8] = 8'(5 + c);
        run_op("row_shift", 3'b010, 200'h100, seq_b, 0, 126, 1'b0, shift_exp);

        run_op("perturb", 3'b010, ident(), fill(8'd3), 1, 126, 1'b0, fill(8'd3));
        run_op("mid_reset", 3'b010, fill(8'd127), fill(8'd127), 2, 126, 1'b0, fill(8'h7F));
        run_op("after_reset", 3'b010, ident(), fill(8'd3), 0, 126, 1'b0, fill(8'd3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
